// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler: collects bits LSB-first and presents a full
// word with a valid/ready handshake. Define ASSEMBLER_FLAGS_EN for all_ones/all_zero flags.
//
// state | meaning
// FILL  | collecting bits into the partial word, bit_ready = 1
// HOLD  | complete word presented on word_out, bit_ready = word_ready
module serial_word_assembler #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [6:0]       bit_count,
  output logic             all_ones,
  output logic             all_zero
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [6:0] LAST = 7'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [6:0]       cnt_q, cnt_d;

  logic             bit_xfer;
  logic             word_done;
  logic             word_taken;
  logic [WIDTH-1:0] data_fill;

  assign bit_ready  = (state_q == HOLD) ? word_ready : 1'b1;
  assign bit_xfer   = bit_valid & bit_ready;
  // Upper bits of data_q are always clean in FILL, so OR-ing in the new bit is enough.
  assign data_fill  = data_q | ({{(WIDTH-1){1'b0}}, bit_in} << cnt_q);
  assign word_done  = (state_q == FILL) && !flush && bit_xfer && (cnt_q == LAST);
  assign word_taken = (state_q == HOLD) && word_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (flush) begin
          data_d = '0;
          cnt_d  = '0;
        end else if (bit_xfer) begin
          data_d = data_fill;
          if (cnt_q == LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d = FILL;
          // A bit offered during the handshake starts the next word.
          if (bit_xfer && !flush) begin
            data_d = {{(WIDTH-1){1'b0}}, bit_in};
            cnt_d  = 7'd1;
          end else begin
            data_d = '0;
            cnt_d  = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
        data_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_valid = (state_q == HOLD);
  assign word_out   = word_valid ? data_q : '0;
  assign bit_count  = cnt_q;

`ifdef ASSEMBLER_FLAGS_EN
  logic ones_q, ones_d;
  logic zero_q, zero_d;

  always_comb begin
    ones_d = ones_q;
    zero_d = zero_q;
    if (word_done) begin
      ones_d = &data_fill;
      zero_d = ~|data_fill;
    end else if (word_taken) begin
      ones_d = 1'b0;
      zero_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ones_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      zero_q <= zero_d;
    end
  end

  assign all_ones = ones_q;
  assign all_zero = zero_q;
`else
  logic unused_flag_terms;
  assign unused_flag_terms = word_done ^ word_taken;
  assign all_ones = 1'b0;
  assign all_zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler: WIDTH=32 instance for the main
// scenarios plus a WIDTH=2 instance for one-bit-per-cycle streaming.
module tb_serial_word_assembler;

`ifdef ASSEMBLER_FLAGS_EN
  localparam logic FLAGS_ON = 1'b1;
`else
  localparam logic FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        bit_in, bit_valid, bit_ready;
  logic [31:0] word_out;
  logic        word_valid, word_ready;
  logic [6:0]  bit_count;
  logic        all_ones, all_zero;

  logic        bit_in2, bit_valid2, bit_ready2;
  logic [1:0]  word_out2;
  logic        word_valid2, word_ready2;
  logic [6:0]  bit_count2;
  logic        all_ones2, all_zero2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  serial_word_assembler #(.WIDTH(32)) dut (
    .clock(clk), .reset(reset), .flush(flush), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .bit_count(bit_count),
    .all_ones(all_ones), .all_zero(all_zero)
  );

  serial_word_assembler #(.WIDTH(2)) dut2 (
    .clock(clk), .reset(reset), .flush(flush), .bit_in(bit_in2),
    .bit_valid(bit_valid2), .bit_ready(bit_ready2), .word_out(word_out2),
    .word_valid(word_valid2), .word_ready(word_ready2), .bit_count(bit_count2),
    .all_ones(all_ones2), .all_zero(all_zero2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bit_valid = 1'b1;
      bit_in    = w[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", word_valid); end
    vectors++; if (word_out !== 32'h0) begin errors++; $display("FAIL reset_word got %h exp 0", word_out); end
    vectors++; if (bit_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bit_count); end
    vectors++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bit_ready); end
    vectors++; if ({all_ones, all_zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {all_ones, all_zero}); end
  endtask

  task automatic test_all_ones();
    word_ready = 1'b1;
    send_bits(32'hFFFF_FFFF, 0, 30);
    vectors++; if (bit_count !== 7'd31) begin errors++; $display("FAIL ones_count31 got %0d exp 31", bit_count); end
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid got %b exp 0", word_valid); end
    send_bits(32'hFFFF_FFFF, 31, 31);
    vectors++; if (word_valid !== 1'b1) begin errors++; $display("FAIL ones_valid got %b exp 1", word_valid); end
    vectors++; if (word_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ones_word got %h exp ffffffff", word_out); end
    vectors++; if (bit_count !== 7'd0) begin errors++; $display("FAIL ones_hold_count got %0d exp 0", bit_count); end
    vectors++; if (all_ones !== FLAGS_ON) begin errors++; $display("FAIL ones_flag got %b exp %b", all_ones, FLAGS_ON); end
    vectors++; if (all_zero !== 1'b0) begin errors++; $display("FAIL ones_zflag got %b exp 0", all_zero); end
    tick();
    word_ready = 1'b0;
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ones_taken got %b exp 0", word_valid); end
    vectors++; if (word_out !== 32'h0) begin errors++; $display("FAIL ones_idle_word got %h exp 0", word_out); end
    vectors++; if (all_ones !== 1'b0) begin errors++; $display("FAIL ones_flag_clr got %b exp 0", all_ones); end
  endtask

  task automatic test_hold_stall();
    word_ready = 1'b0;
    send_bits(32'h0000_0001, 0, 31);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (word_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d got %b exp 1", c, word_valid); end
      vectors++; if (word_out !== 32'h0000_0001) begin errors++; $display("FAIL stall_word c%0d got %h exp 00000001", c, word_out); end
      vectors++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d got %b exp 0", c, bit_ready); end
      tick();
    end
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", word_valid); end
    vectors++; if (bit_count !== 7'd0) begin errors++; $display("FAIL stall_count got %0d exp 0", bit_count); end
  endtask

  task automatic test_back_to_back();
    word_ready = 1'b0;
    send_bits(32'hA5A5_A5A5, 0, 31);
    vectors++; if (word_out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL b2b_word1 got %h exp a5a5a5a5", word_out); end
    vectors++; if ({all_ones, all_zero} !== 2'b00) begin errors++; $display("FAIL b2b_flags got %b exp 00", {all_ones, all_zero}); end
    word_ready = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = 1'b1;
    tick();
    word_ready = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    vectors++; if (bit_count !== 7'd1) begin errors++; $display("FAIL b2b_count got %0d exp 1", bit_count); end
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b exp 0", word_valid); end
    send_bits(32'h8000_0003, 1, 31);
    vectors++; if (word_out !== 32'h8000_0003) begin errors++; $display("FAIL b2b_word2 got %h exp 80000003", word_out); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic test_flush();
    word_ready = 1'b0;
    send_bits(32'hFFFF_FFFF, 0, 16);
    vectors++; if (bit_count !== 7'd17) begin errors++; $display("FAIL flush_pre_count got %0d exp 17", bit_count); end
    flush     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    flush     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    vectors++; if (bit_count !== 7'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", bit_count); end
    send_bits(32'h1234_0000, 0, 31);
    vectors++; if (word_out !== 32'h1234_0000) begin errors++; $display("FAIL flush_word got %h exp 12340000", word_out); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (word_valid !== 1'b1) begin errors++; $display("FAIL flush_hold_valid got %b exp 1", word_valid); end
    vectors++; if (word_out !== 32'h1234_0000) begin errors++; $display("FAIL flush_hold_word got %h exp 12340000", word_out); end
    vectors++; if (bit_count !== 7'd0) begin errors++; $display("FAIL flush_hold_count got %0d exp 0", bit_count); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    word_ready = 1'b0;
    send_bits(32'hFFFF_FFFF, 0, 19);
    vectors++; if (bit_count !== 7'd20) begin errors++; $display("FAIL rst_mid_pre got %0d exp 20", bit_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (bit_count !== 7'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", bit_count); end
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", word_valid); end
    send_bits(32'hFFFF_FFFF, 0, 31);
    vectors++; if (word_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mid_clean got %h exp ffffffff", word_out); end
    reset      = 1'b1;
    word_ready = 1'b1;
    tick();
    reset      = 1'b0;
    word_ready = 1'b0;
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got %b exp 0", word_valid); end
    vectors++; if (word_out !== 32'h0) begin errors++; $display("FAIL rst_hold_word got %h exp 0", word_out); end
    vectors++; if (bit_count !== 7'd0) begin errors++; $display("FAIL rst_hold_count got %0d exp 0", bit_count); end
    vectors++; if ({all_ones, all_zero} !== 2'b00) begin errors++; $display("FAIL rst_hold_flags got %b exp 00", {all_ones, all_zero}); end
    vectors++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_ready got %b exp 1", bit_ready); end
  endtask

  task automatic test_all_zero();
    word_ready = 1'b0;
    send_bits(32'h0, 0, 31);
    vectors++; if (word_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b exp 1", word_valid); end
    vectors++; if (word_out !== 32'h0) begin errors++; $display("FAIL zero_word got %h exp 0", word_out); end
    vectors++; if (all_zero !== FLAGS_ON) begin errors++; $display("FAIL zero_flag got %b exp %b", all_zero, FLAGS_ON); end
    vectors++; if (all_ones !== 1'b0) begin errors++; $display("FAIL zero_oflag got %b exp 0", all_ones); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic test_width2_stream();
    logic [5:0] bits;
    logic [1:0] exp_words [3];
    bits = 6'b011101;          // sent in order bit0..bit5 = 1,0,1,1,1,0
    exp_words[0] = 2'b01;
    exp_words[1] = 2'b11;
    exp_words[2] = 2'b01;
    word_ready2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit_valid2 = 1'b1;
      bit_in2    = bits[i];
      tick();
      if (i % 2 == 1) begin
        vectors++; if (word_valid2 !== 1'b1) begin errors++; $display("FAIL w2_valid i%0d got %b exp 1", i, word_valid2); end
        vectors++; if (word_out2 !== exp_words[i/2]) begin errors++; $display("FAIL w2_word i%0d got %b exp %b", i, word_out2, exp_words[i/2]); end
        vectors++; if (bit_ready2 !== 1'b1) begin errors++; $display("FAIL w2_ready i%0d got %b exp 1", i, bit_ready2); end
      end else begin
        vectors++; if (bit_count2 !== 7'd1) begin errors++; $display("FAIL w2_count i%0d got %0d exp 1", i, bit_count2); end
      end
    end
    bit_valid2 = 1'b0;
    bit_in2    = 1'b0;
    tick();
    vectors++; if (word_valid2 !== 1'b0) begin errors++; $display("FAIL w2_drain got %b exp 0", word_valid2); end
    word_ready2 = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    word_ready  = 1'b0;
    bit_in2     = 1'b0;
    bit_valid2  = 1'b0;
    word_ready2 = 1'b0;
    test_reset();
    test_all_ones();
    test_hold_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_all_zero();
    test_width2_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
